// File: rtl/icache_mem_arb_pkg.sv
// Shared types for the instruction-cache / prefetcher memory-port arbiter.
package icache_mem_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_e;

  typedef logic port_id_t;

endpackage

// File: rtl/icache_mem_arbiter_pick.sv
// Combinational two-way picker: round-robin against the last granted port,
// or fixed priority with port 0 always winning.
module mem_arb_pick
  import icache_mem_arb_pkg::*;
#(
  parameter int FIXED_PRIO = 0
) (
  input  logic [NUM_PORTS-1:0] valid,
  input  port_id_t             last,
  output port_id_t             gnt_id,
  output logic                 gnt_any
);

  always_comb begin
    gnt_any = |valid;
    gnt_id  = 1'b0;
    if (FIXED_PRIO != 0) begin
      gnt_id = ~valid[0];
    end else if (valid[0] && valid[1]) begin
      // Tie: favour the port that was not served last.
      gnt_id = ~last;
    end else begin
      gnt_id = valid[1];
    end
  end

endmodule

// File: rtl/icache_mem_arbiter.sv
// Shares one line-read memory port between icache refill (port 0) and the
// prefetcher (port 1); one transaction in flight, withdrawn responses dropped.
module icache_mem_arbiter
  import icache_mem_arb_pkg::*;
#(
  parameter int LINE_BYTES = 16,
  parameter int ADDR_W     = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    c0_req_valid,
  input  logic [ADDR_W-1:0]       c0_req_addr,
  output logic                    c0_req_ready,
  output logic [8*LINE_BYTES-1:0] c0_req_rdata,
  input  logic                    c1_req_valid,
  input  logic [ADDR_W-1:0]       c1_req_addr,
  output logic                    c1_req_ready,
  output logic [8*LINE_BYTES-1:0] c1_req_rdata,
  output logic                    mem_req_valid,
  output logic [ADDR_W-1:0]       mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic [8*LINE_BYTES-1:0] mem_req_rdata,
  output logic [31:0]             dbg_grant_cnt0,
  output logic [31:0]             dbg_grant_cnt1,
  output logic [31:0]             dbg_drop_cnt
);

  localparam int DATA_W = 8 * LINE_BYTES;

  arb_state_e             state_q;
  port_id_t               gnt_id_q;
  port_id_t               last_q;
  logic                   abandoned_q;
  logic                   abandoned_d;
  logic                   mem_valid_q;
  logic [ADDR_W-1:0]      addr_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [NUM_PORTS-1:0]   ready_q;
  logic [31:0]            grant_cnt0_q;
  logic [31:0]            grant_cnt1_q;
  logic [31:0]            drop_cnt_q;

  logic [NUM_PORTS-1:0]   req_valid;
  port_id_t               pick_id;
  logic                   pick_any;

  assign req_valid = {c1_req_valid, c0_req_valid};

  mem_arb_pick #(
    .FIXED_PRIO(FIXED_PRIO)
  ) u_pick (
    .valid  (req_valid),
    .last   (last_q),
    .gnt_id (pick_id),
    .gnt_any(pick_any)
  );

  // Sticky: a single low cycle on the granted valid abandons the transaction.
  assign abandoned_d = abandoned_q | ~req_valid[gnt_id_q];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      gnt_id_q     <= 1'b0;
      last_q       <= 1'b1;
      abandoned_q  <= 1'b0;
      mem_valid_q  <= 1'b0;
      addr_q       <= '0;
      rdata_q      <= '0;
      ready_q      <= '0;
      grant_cnt0_q <= '0;
      grant_cnt1_q <= '0;
      drop_cnt_q   <= '0;
    end else begin
      ready_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_any) begin
            gnt_id_q    <= pick_id;
            addr_q      <= pick_id ? c1_req_addr : c0_req_addr;
            abandoned_q <= 1'b0;
            mem_valid_q <= 1'b1;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          abandoned_q <= abandoned_d;
          if (mem_req_ready) begin
            rdata_q     <= mem_req_rdata;
            mem_valid_q <= 1'b0;
            state_q     <= RESP;
            if (!abandoned_d) begin
              ready_q[gnt_id_q] <= 1'b1;
            end
          end
        end
        RESP: begin
          // Ready pulse is visible this cycle; book-keep and return to IDLE.
          if (abandoned_q) begin
            drop_cnt_q <= drop_cnt_q + 32'd1;
          end else begin
            last_q <= gnt_id_q;
            if (gnt_id_q) begin
              grant_cnt1_q <= grant_cnt1_q + 32'd1;
            end else begin
              grant_cnt0_q <= grant_cnt0_q + 32'd1;
            end
          end
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req_valid  = mem_valid_q;
  assign mem_req_addr   = addr_q;
  assign c0_req_ready   = ready_q[0];
  assign c1_req_ready   = ready_q[1];
  assign c0_req_rdata   = rdata_q;
  assign c1_req_rdata   = rdata_q;
  assign dbg_grant_cnt0 = grant_cnt0_q;
  assign dbg_grant_cnt1 = grant_cnt1_q;
  assign dbg_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_icache_mem_arbiter.sv
// Directed bench for icache_mem_arbiter: a round-robin instance and a
// fixed-priority instance, each with a latency-programmable memory model.
module tb_icache_mem_arbiter;

  logic clk;
  logic reset;

  // Round-robin instance requesters
  logic         c0_valid, c1_valid;
  logic [31:0]  c0_addr, c1_addr;
  logic         c0_ready, c1_ready;
  logic [127:0] c0_rdata, c1_rdata;
  logic [31:0]  gcnt0, gcnt1, dcnt;

  // Fixed-priority instance requesters
  logic         f0_valid, f1_valid;
  logic [31:0]  f0_addr, f1_addr;
  logic         f0_ready, f1_ready;
  logic [127:0] f0_rdata, f1_rdata;
  logic [31:0]  fgcnt0, fgcnt1, fdcnt;

  // Memory side, index 0 = round-robin DUT, 1 = fixed-priority DUT
  logic         m_valid [2];
  logic [31:0]  m_addr  [2];
  logic         m_ready [2];
  logic [127:0] m_rdata [2];
  int           wcnt    [2];
  int           rdy_left[2];
  int           mem_lat;
  int           mem_hold;

  int vecs;
  int errs;

  icache_mem_arbiter #(.LINE_BYTES(16), .ADDR_W(32), .FIXED_PRIO(0)) u_rr (
    .clk(clk), .reset(reset),
    .c0_req_valid(c0_valid), .c0_req_addr(c0_addr), .c0_req_ready(c0_ready), .c0_req_rdata(c0_rdata),
    .c1_req_valid(c1_valid), .c1_req_addr(c1_addr), .c1_req_ready(c1_ready), .c1_req_rdata(c1_rdata),
    .mem_req_valid(m_valid[0]), .mem_req_addr(m_addr[0]),
    .mem_req_ready(m_ready[0]), .mem_req_rdata(m_rdata[0]),
    .dbg_grant_cnt0(gcnt0), .dbg_grant_cnt1(gcnt1), .dbg_drop_cnt(dcnt)
  );

  icache_mem_arbiter #(.LINE_BYTES(16), .ADDR_W(32), .FIXED_PRIO(1)) u_fix (
    .clk(clk), .reset(reset),
    .c0_req_valid(f0_valid), .c0_req_addr(f0_addr), .c0_req_ready(f0_ready), .c0_req_rdata(f0_rdata),
    .c1_req_valid(f1_valid), .c1_req_addr(f1_addr), .c1_req_ready(f1_ready), .c1_req_rdata(f1_rdata),
    .mem_req_valid(m_valid[1]), .mem_req_addr(m_addr[1]),
    .mem_req_ready(m_ready[1]), .mem_req_rdata(m_rdata[1]),
    .dbg_grant_cnt0(fgcnt0), .dbg_grant_cnt1(fgcnt1), .dbg_drop_cnt(fdcnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] line_of(input logic [31:0] a);
    return {a, ~a, a ^ 32'h5A5A_5A5A, a + 32'h1111_1111};
  endfunction

  // Memory answers in the (mem_lat+1)-th cycle of valid, holding ready mem_hold cycles.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 2; i++) begin
      if (rdy_left[i] > 0) begin
        rdy_left[i] = rdy_left[i] - 1;
      end else if (m_valid[i] && !reset) begin
        wcnt[i] = wcnt[i] + 1;
        if (wcnt[i] == mem_lat + 1) begin
          rdy_left[i] = mem_hold;
          wcnt[i]     = 0;
        end
      end else begin
        wcnt[i] = 0;
      end
      m_ready[i] = (rdy_left[i] > 0);
      m_rdata[i] = line_of(m_addr[i]);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    c0_valid = 0; c1_valid = 0; f0_valid = 0; f1_valid = 0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    tick();
    tick();
    if (c0_ready !== 1'b0 || c1_ready !== 1'b0) begin
      $display("FAIL reset_ready got %b%b exp 00", c1_ready, c0_ready); errs++;
    end
    vecs++;
    if (c0_rdata !== 128'd0 || c1_rdata !== 128'd0) begin
      $display("FAIL reset_rdata got %h exp 0", c0_rdata); errs++;
    end
    vecs++;
    if (m_valid[0] !== 1'b0 || m_addr[0] !== 32'd0) begin
      $display("FAIL reset_mem got valid=%b addr=%h exp 0/0", m_valid[0], m_addr[0]); errs++;
    end
    vecs++;
    if (gcnt0 !== 0 || gcnt1 !== 0 || dcnt !== 0 || fgcnt0 !== 0 || fgcnt1 !== 0 || fdcnt !== 0) begin
      $display("FAIL reset_counters got %0d %0d %0d exp 0 0 0", gcnt0, gcnt1, dcnt); errs++;
    end
    vecs++;
    reset = 1'b0;
  endtask

  task automatic test_single();
    mem_lat = 3; mem_hold = 1;
    c0_addr = 32'h0000_1230; c0_valid = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k <= 4) begin
        if (m_valid[0] !== 1'b1) begin
          $display("FAIL single_mem_valid k=%0d got %b exp 1", k, m_valid[0]); errs++;
        end
        vecs++;
        if (m_addr[0] !== 32'h0000_1230) begin
          $display("FAIL single_mem_addr k=%0d got %h exp 00001230", k, m_addr[0]); errs++;
        end
        vecs++;
        if (c0_ready !== 1'b0) begin
          $display("FAIL single_early_ready k=%0d got %b exp 0", k, c0_ready); errs++;
        end
        vecs++;
      end else if (k == 5) begin
        if (c0_ready !== 1'b1 || c1_ready !== 1'b0) begin
          $display("FAIL single_ready got c0=%b c1=%b exp 1/0", c0_ready, c1_ready); errs++;
        end
        vecs++;
        if (c0_rdata !== line_of(32'h0000_1230)) begin
          $display("FAIL single_rdata got %h exp %h", c0_rdata, line_of(32'h0000_1230)); errs++;
        end
        vecs++;
        if (m_valid[0] !== 1'b0) begin
          $display("FAIL single_mem_drop got %b exp 0", m_valid[0]); errs++;
        end
        vecs++;
        c0_valid = 1'b0;
      end else if (k == 7) begin
        if (gcnt0 !== 32'd1) begin
          $display("FAIL single_cnt0 got %0d exp 1", gcnt0); errs++;
        end
        vecs++;
      end
    end
  endtask

  task automatic test_rr_tie();
    do_reset();
    mem_lat = 3; mem_hold = 1;
    c0_addr = 32'h0000_0100; c1_addr = 32'h0000_0200;
    c0_valid = 1'b1; c1_valid = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin
        if (m_valid[0] !== 1'b1 || m_addr[0] !== 32'h100) begin
          $display("FAIL tie_first_grant got valid=%b addr=%h exp 1/100", m_valid[0], m_addr[0]); errs++;
        end
        vecs++;
      end else if (k == 5) begin
        if (c0_ready !== 1'b1 || c1_ready !== 1'b0) begin
          $display("FAIL tie_c0_ready got c0=%b c1=%b exp 1/0", c0_ready, c1_ready); errs++;
        end
        vecs++;
        if (c0_rdata !== line_of(32'h100)) begin
          $display("FAIL tie_c0_rdata got %h exp %h", c0_rdata, line_of(32'h100)); errs++;
        end
        vecs++;
        c0_valid = 1'b0;
      end else if (k == 6) begin
        if (m_valid[0] !== 1'b0) begin
          $display("FAIL tie_gap got %b exp 0", m_valid[0]); errs++;
        end
        vecs++;
      end else if (k == 7) begin
        if (m_valid[0] !== 1'b1 || m_addr[0] !== 32'h200) begin
          $display("FAIL tie_second_grant got valid=%b addr=%h exp 1/200", m_valid[0], m_addr[0]); errs++;
        end
        vecs++;
      end else if (k == 11) begin
        if (c1_ready !== 1'b1 || c0_ready !== 1'b0) begin
          $display("FAIL tie_c1_ready got c1=%b c0=%b exp 1/0", c1_ready, c0_ready); errs++;
        end
        vecs++;
        if (c1_rdata !== line_of(32'h200)) begin
          $display("FAIL tie_c1_rdata got %h exp %h", c1_rdata, line_of(32'h200)); errs++;
        end
        vecs++;
        c1_valid = 1'b0;
      end else if (k == 12) begin
        if (gcnt0 !== 32'd1 || gcnt1 !== 32'd1) begin
          $display("FAIL tie_counts got %0d/%0d exp 1/1", gcnt0, gcnt1); errs++;
        end
        vecs++;
      end
    end
  endtask

  task automatic test_fixed_prio();
    int served = 0;
    int f1_seen = 0;
    int cyc = 0;
    do_reset();
    mem_lat = 2; mem_hold = 1;
    f1_addr = 32'h0000_0900; f1_valid = 1'b1;
    f0_addr = 32'h0000_1000; f0_valid = 1'b1;
    while (served < 10 && cyc < 300) begin
      tick(); cyc++;
      if (f1_ready) f1_seen++;
      if (f0_ready) begin
        if (f0_rdata !== line_of(f0_addr)) begin
          $display("FAIL fixed_rdata n=%0d got %h exp %h", served, f0_rdata, line_of(f0_addr)); errs++;
        end
        vecs++;
        served++;
        f0_valid = 1'b0;
        tick(); cyc++;
        if (f1_ready) f1_seen++;
        f0_addr  = 32'h0000_1000 + 32'h40 * served;
        f0_valid = (served < 10);
      end
    end
    if (served !== 10) begin
      $display("FAIL fixed_served got %0d exp 10", served); errs++;
    end
    vecs++;
    if (f1_seen !== 0) begin
      $display("FAIL fixed_c1_ready got %0d pulses exp 0", f1_seen); errs++;
    end
    vecs++;
    if (fgcnt0 !== 32'd10 || fgcnt1 !== 32'd0) begin
      $display("FAIL fixed_counts got %0d/%0d exp 10/0", fgcnt0, fgcnt1); errs++;
    end
    vecs++;
    f1_valid = 1'b0;
  endtask

  task automatic test_abandon();
    int pulses = 0;
    int waited = 0;
    do_reset();
    mem_lat = 5; mem_hold = 1;
    c0_addr = 32'h0000_0300; c0_valid = 1'b1;
    tick();
    tick();
    c0_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (c0_ready) pulses++;
    end
    if (pulses !== 0) begin
      $display("FAIL abandon_ready got %0d pulses exp 0", pulses); errs++;
    end
    vecs++;
    if (dcnt !== 32'd1 || gcnt0 !== 32'd0) begin
      $display("FAIL abandon_counts got drop=%0d cnt0=%0d exp 1/0", dcnt, gcnt0); errs++;
    end
    vecs++;
    c0_addr = 32'h0000_0340; c0_valid = 1'b1;
    while (!c0_ready && waited < 20) begin
      tick(); waited++;
    end
    if (c0_ready !== 1'b1 || c0_rdata !== line_of(32'h340)) begin
      $display("FAIL abandon_next got ready=%b rdata=%h exp 1/%h", c0_ready, c0_rdata, line_of(32'h340)); errs++;
    end
    vecs++;
    c0_valid = 1'b0;
    tick();
    if (gcnt0 !== 32'd1 || dcnt !== 32'd1) begin
      $display("FAIL abandon_after got cnt0=%0d drop=%0d exp 1/1", gcnt0, dcnt); errs++;
    end
    vecs++;
  endtask

  task automatic test_mem_hold();
    int pulses = 0;
    int vcyc = 0;
    mem_lat = 2; mem_hold = 2;
    c1_addr = 32'h0000_0500; c1_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (m_valid[0]) vcyc++;
      if (c1_ready) begin
        pulses++;
        if (c1_rdata !== line_of(32'h500)) begin
          $display("FAIL hold_rdata got %h exp %h", c1_rdata, line_of(32'h500)); errs++;
        end
        vecs++;
        c1_valid = 1'b0;
      end
    end
    if (pulses !== 1) begin
      $display("FAIL hold_pulses got %0d exp 1", pulses); errs++;
    end
    vecs++;
    if (vcyc !== 3) begin
      $display("FAIL hold_mem_valid_cycles got %0d exp 3", vcyc); errs++;
    end
    vecs++;
    if (gcnt1 !== 32'd1) begin
      $display("FAIL hold_cnt1 got %0d exp 1", gcnt1); errs++;
    end
    vecs++;
    mem_hold = 1;
  endtask

  task automatic test_reset_mid_wait();
    int waited = 0;
    mem_lat = 6; mem_hold = 1;
    c0_addr = 32'h0000_0600; c0_valid = 1'b1;
    tick();
    tick();
    if (m_valid[0] !== 1'b1) begin
      $display("FAIL rst_pre_valid got %b exp 1", m_valid[0]); errs++;
    end
    vecs++;
    #3;
    reset = 1'b1;
    #1;
    if (m_valid[0] !== 1'b0 || m_addr[0] !== 32'd0) begin
      $display("FAIL rst_async got valid=%b addr=%h exp 0/0", m_valid[0], m_addr[0]); errs++;
    end
    vecs++;
    if (gcnt0 !== 0 || gcnt1 !== 0 || dcnt !== 0) begin
      $display("FAIL rst_counters got %0d %0d %0d exp 0 0 0", gcnt0, gcnt1, dcnt); errs++;
    end
    vecs++;
    c1_addr = 32'h0000_0700; c1_valid = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    if (m_valid[0] !== 1'b1 || m_addr[0] !== 32'h600) begin
      $display("FAIL rst_tie_grant got valid=%b addr=%h exp 1/600", m_valid[0], m_addr[0]); errs++;
    end
    vecs++;
    while (!c0_ready && waited < 20) begin
      tick(); waited++;
    end
    if (c0_ready !== 1'b1 || c1_ready !== 1'b0 || c0_rdata !== line_of(32'h600)) begin
      $display("FAIL rst_first_served got c0=%b c1=%b rdata=%h exp 1/0/%h", c0_ready, c1_ready, c0_rdata, line_of(32'h600)); errs++;
    end
    vecs++;
    c0_valid = 1'b0; c1_valid = 1'b0;
    tick();
    if (gcnt0 !== 32'd1 || gcnt1 !== 32'd0) begin
      $display("FAIL rst_after_counts got %0d/%0d exp 1/0", gcnt0, gcnt1); errs++;
    end
    vecs++;
  endtask

  initial begin
    vecs = 0; errs = 0;
    mem_lat = 3; mem_hold = 1;
    reset = 1'b1;
    c0_valid = 0; c1_valid = 0; f0_valid = 0; f1_valid = 0;
    c0_addr = 0; c1_addr = 0; f0_addr = 0; f1_addr = 0;
    test_reset();
    test_single();
    test_rr_tie();
    test_fixed_prio();
    test_abandon();
    test_mem_hold();
    test_reset_mid_wait();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout exp completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/icache_mem_arbiter.md
# icache_mem_arbiter

Two-requester arbiter that shares the single wide line-read memory port between the instruction-cache refill path (port 0) and the instruction prefetcher (port 1). It sits between the caches and the memory model/controller. Toward each requester it presents the same valid/ready line-read handshake the cache already uses, so the cache connects without modification. It serialises requests, keeps one transaction outstanding at a time, and drops the response of a requester that withdraws its request mid-transaction.

## Interface
Parameters:
- LINE_BYTES, 16, bytes per line; data width is 8*LINE_BYTES.
- ADDR_W, 32, address width.
- FIXED_PRIO, 0, selects arbitration policy: 0 = round-robin, 1 = port 0 always wins.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- c0_req_valid / c1_req_valid  in  1  requester holds high until it sees ready.
- c0_req_addr / c1_req_addr  in  ADDR_W  line-aligned request address.
- c0_req_ready / c1_req_ready  out  1  one-cycle pulse; rdata is valid in the same cycle.
- c0_req_rdata / c1_req_rdata  out  8*LINE_BYTES  returned line.
- mem_req_valid  out  1  request to memory.
- mem_req_addr  out  ADDR_W  registered address to memory.
- mem_req_ready  in  1  memory response strobe; rdata is valid while high.
- mem_req_rdata  in  8*LINE_BYTES  line from memory.
- dbg_grant_cnt0 / dbg_grant_cnt1  out  32  count of completed transactions per port; wraps.
- dbg_drop_cnt  out  32  count of responses discarded because the requester withdrew.

## Operation
- The FSM has three states: IDLE, WAIT, RESP. Reset enters IDLE.
- IDLE, no valid request: hold.
- IDLE, one or more valid requests:
  - Pick a winner. Round-robin favours the port not granted last; the `last` pointer resets to 1, so port 0 wins the first tie.
  - Latch the winner's id and address into mem_req_addr.
  - Set mem_req_valid=1 and go to WAIT.
- WAIT:
  - Hold mem_req_valid=1 and mem_req_addr constant.
  - Continuously sample the granted port's valid into an `abandoned` flag. Once set, the flag stays set for the rest of the transaction.
  - On mem_req_ready=1: register mem_req_rdata, set mem_req_valid=0, go to RESP.
- RESP, lasting exactly one cycle:
  - If not abandoned: pulse cN_req_ready=1 on the granted port and drive rdata. Increment dbg_grant_cntN and update the `last` pointer.
  - If abandoned: no ready pulse; increment dbg_drop_cnt.
  - Go to IDLE.
- The non-granted port's ready is always 0. Both rdata outputs drive the registered line; only the ready pulse qualifies it.
- mem_req_ready is ignored outside WAIT. This covers memory holding ready high for an extra cycle after valid drops.
- A requester that changes its address while granted is not re-sampled; the latched address is used.
- Counter arithmetic is modulo 2^32.

## Timing
- Reset values: every ready=0, rdata=0, mem_req_valid=0, mem_req_addr=0, all counters=0, state IDLE, last=1, abandoned=0.
- Asserting reset during WAIT or RESP drops mem_req_valid immediately (asynchronously). Any in-flight response is lost with no ready pulse.
- Request seen in IDLE at cycle t: mem_req_valid=1 from cycle t+1.
- mem_req_ready at cycle m: mem_req_valid=0 and cN_req_ready=1 at cycle m+1.
- Latency from requester valid to requester ready = memory latency + 2 cycles minimum.
- Back-to-back: the earliest next grant is sampled in IDLE at m+2, with mem_req_valid=1 at m+3. The requester drops valid in the cycle after its ready pulse, so it is never re-granted spuriously.
- Simultaneous requests in IDLE: exactly one grant per arbitration decision. The loser waits with its valid held and wins the next IDLE cycle in round-robin mode.
- FIXED_PRIO=1: port 1 can starve. This is accepted; port 1 is a prefetcher.

## Structure
- Package icache_mem_arb_pkg holds:
  - the state enum (IDLE, WAIT, RESP);
  - the port-id type (1 bit);
  - NUM_PORTS=2.
- Sub-module mem_arb_pick: a combinational two-way picker.
  - Inputs: valid[1:0], last, FIXED_PRIO.
  - Outputs: gnt_id, gnt_any.
  - The FSM, registered datapath and counters stay in the top module.

## Test plan
- Single request on c0, addr 0x0000_1230, memory latency 3 → mem_req_addr=0x1230 from t+1; c0_req_ready pulses at t+5 with the memory line; dbg_grant_cnt0=1.
- c0 and c1 valid in the same cycle, round-robin → c0 served first, then c1; mem_req_valid low for exactly one cycle between the two transactions; both counters =1.
- FIXED_PRIO=1, c0 re-requests continuously (10 requests) while c1 is held valid → c1 never readied; dbg_grant_cnt0=10.
- c0 drops valid two cycles into WAIT → memory transaction completes; c0_req_ready never pulses; dbg_drop_cnt=1; the next request is granted normally.
- Memory holds mem_req_ready high for 2 cycles → only one requester ready pulse; no second transaction issued.
- reset asserted mid-WAIT → mem_req_valid=0 immediately; all counters 0; first request after reset is served with port-0 tie priority.
